// File: rtl/uart_frame_rx.sv
// -----------------------------------------------------------------------------
// uart_frame_rx
//
// Frame parser placed directly behind the UART receive FIFO. Bytes are popped
// whenever the FIFO is non-empty and are split into frames of the form
//    SOF, LEN, payload[LEN] (, checksum)
// Payload bytes leave as a valid/last stream. Each frame ends with either a
// frame_done pulse or a frame_err pulse carrying a cause code. A gap of
// TO_CYCLES empty cycles inside a frame aborts it.
//
// Build option:
//    UART_FRAME_CSUM_EN  when defined, a trailing checksum byte is expected.
//                        The checksum is the XOR of LEN and all payload bytes.
//                        When undefined, the frame ends on its last payload
//                        byte and frame_done pulses together with pl_last.
//
// Ports:
//    clk         rising-edge clock
//    reset       asynchronous active-high reset
//    rx_empty    FIFO empty flag
//    r_data      FIFO head byte, valid while rx_empty = 0
//    rd_uart     FIFO pop (combinational, = ~rx_empty)
//    pl_data     payload byte (registered)
//    pl_valid    one-cycle qualifier for pl_data
//    pl_last     marks the final payload byte of a frame
//    frame_done  one-cycle pulse, frame accepted
//    frame_err   one-cycle pulse, frame aborted
//    err_code    cause of the most recent error:
//                0 none, 1 checksum, 2 bad length, 3 timeout
// -----------------------------------------------------------------------------
module uart_frame_rx #(
   parameter int         DBIT      = 8,
   parameter logic [7:0] SOF       = 8'hA5,
   parameter int         MAX_LEN   = 16,
   parameter int         TO_CYCLES = 1000,
   parameter int         TO_BIT    = 10
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx_empty,
   input  logic [DBIT-1:0] r_data,
   output logic            rd_uart,
   output logic [DBIT-1:0] pl_data,
   output logic            pl_valid,
   output logic            pl_last,
   output logic            frame_done,
   output logic            frame_err,
   output logic [1:0]      err_code
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LEN  = 2'd1,
`ifdef UART_FRAME_CSUM_EN
      ST_DATA = 2'd2,
      ST_CSUM = 2'd3
`else
      ST_DATA = 2'd2
`endif
   } state_t;

   localparam logic [1:0]        ERR_CSUM  = 2'd1;
   localparam logic [1:0]        ERR_LEN   = 2'd2;
   localparam logic [1:0]        ERR_TO    = 2'd3;
   // The timeout fires on the TO_CYCLES-th consecutive empty cycle, i.e. when
   // the counter already holds TO_CYCLES-1 and the FIFO is still empty.
   localparam logic [TO_BIT-1:0] TO_LAST   = TO_BIT'(TO_CYCLES - 1);
   localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);

`ifdef UART_FRAME_CSUM_EN
   // One step of the running XOR checksum.
   function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction
`endif

   state_t            state_r, state_s;
   logic              consume_s, to_fire_s, len_bad_s, last_byte_s;
   logic [7:0]        cnt_r, cnt_s;
   logic [TO_BIT-1:0] to_cnt_r, to_cnt_s;
`ifdef UART_FRAME_CSUM_EN
   logic [7:0]        acc_r, acc_s;
`endif
   logic [DBIT-1:0]   pl_data_r, pl_data_s;
   logic              pl_valid_r, pl_valid_s;
   logic              pl_last_r, pl_last_s;
   logic              done_r, done_s;
   logic              err_r, err_s;
   logic [1:0]        code_r, code_s;

   assign rd_uart     = ~rx_empty;
   assign consume_s   = ~rx_empty;
   assign to_fire_s   = (state_r != ST_IDLE) && rx_empty && (to_cnt_r == TO_LAST);
   assign len_bad_s   = (r_data == 8'd0) || (r_data > MAX_LEN_B);
   assign last_byte_s = (cnt_r == 8'd1);

   assign pl_data    = pl_data_r;
   assign pl_valid   = pl_valid_r;
   assign pl_last    = pl_last_r;
   assign frame_done = done_r;
   assign frame_err  = err_r;
   assign err_code   = code_r;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; a consumed byte always takes priority over a timeout.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (consume_s && (r_data == SOF)) begin
               state_s = ST_LEN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LEN: begin
            if (consume_s) begin
               state_s = len_bad_s ? ST_IDLE : ST_DATA;
            end else if (to_fire_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_LEN;
            end
         end
         ST_DATA: begin
            if (consume_s && last_byte_s) begin
`ifdef UART_FRAME_CSUM_EN
               state_s = ST_CSUM;
`else
               state_s = ST_IDLE;
`endif
            end else if (!consume_s && to_fire_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DATA;
            end
         end
`ifdef UART_FRAME_CSUM_EN
         ST_CSUM: begin
            if (consume_s || to_fire_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_CSUM;
            end
         end
`endif
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Output and datapath next values: payload stream, pulses, counters, checksum.
   always_comb begin
      pl_data_s  = pl_data_r;
      pl_valid_s = 1'b0;
      pl_last_s  = 1'b0;
      done_s     = 1'b0;
      err_s      = 1'b0;
      code_s     = code_r;
      cnt_s      = cnt_r;
`ifdef UART_FRAME_CSUM_EN
      acc_s      = acc_r;
`endif
      // Idle-gap counter runs only inside a frame and restarts on every byte.
      if ((state_r == ST_IDLE) || consume_s || to_fire_s) begin
         to_cnt_s = '0;
      end else begin
         to_cnt_s = to_cnt_r + TO_BIT'(1);
      end

      case (state_r)
         ST_IDLE: begin
            if (consume_s && (r_data == SOF)) begin
               cnt_s = 8'd0;
`ifdef UART_FRAME_CSUM_EN
               acc_s = 8'd0;
`endif
            end else begin
               cnt_s = cnt_r;
            end
         end
         ST_LEN: begin
            if (consume_s) begin
               if (len_bad_s) begin
                  err_s  = 1'b1;
                  code_s = ERR_LEN;
               end else begin
                  cnt_s = r_data;
`ifdef UART_FRAME_CSUM_EN
                  acc_s = r_data;
`endif
               end
            end else if (to_fire_s) begin
               err_s  = 1'b1;
               code_s = ERR_TO;
            end else begin
               err_s = 1'b0;
            end
         end
         ST_DATA: begin
            if (consume_s) begin
               pl_valid_s = 1'b1;
               pl_data_s  = r_data;
               cnt_s      = cnt_r - 8'd1;
`ifdef UART_FRAME_CSUM_EN
               acc_s      = csum_step(acc_r, r_data);
`endif
               if (last_byte_s) begin
                  pl_last_s = 1'b1;
`ifndef UART_FRAME_CSUM_EN
                  done_s    = 1'b1;
`endif
               end else begin
                  pl_last_s = 1'b0;
               end
            end else if (to_fire_s) begin
               err_s  = 1'b1;
               code_s = ERR_TO;
            end else begin
               err_s = 1'b0;
            end
         end
`ifdef UART_FRAME_CSUM_EN
         ST_CSUM: begin
            if (consume_s) begin
               if (r_data == acc_r) begin
                  done_s = 1'b1;
               end else begin
                  err_s  = 1'b1;
                  code_s = ERR_CSUM;
               end
            end else if (to_fire_s) begin
               err_s  = 1'b1;
               code_s = ERR_TO;
            end else begin
               err_s = 1'b0;
            end
         end
`endif
         default: begin
            cnt_s = 8'd0;
         end
      endcase
   end

   // Registered outputs, counters and checksum accumulator.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pl_data_r  <= '0;
         pl_valid_r <= 1'b0;
         pl_last_r  <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         code_r     <= 2'd0;
         cnt_r      <= 8'd0;
         to_cnt_r   <= '0;
`ifdef UART_FRAME_CSUM_EN
         acc_r      <= 8'd0;
`endif
      end else begin
         pl_data_r  <= pl_data_s;
         pl_valid_r <= pl_valid_s;
         pl_last_r  <= pl_last_s;
         done_r     <= done_s;
         err_r      <= err_s;
         code_r     <= code_s;
         cnt_r      <= cnt_s;
         to_cnt_r   <= to_cnt_s;
`ifdef UART_FRAME_CSUM_EN
         acc_r      <= acc_s;
`endif
      end
   end

endmodule

// File: tb/tb_uart_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_rx
//
// Directed bench for uart_frame_rx. A table of {FIFO input, expected outputs}
// records is applied one cycle per record; hand-written sequences cover the
// idle-gap timeout boundary and reset in the middle of a frame. Expected
// values follow the build option UART_FRAME_CSUM_EN.
// -----------------------------------------------------------------------------
module tb_uart_frame_rx;

   localparam int MAX_LEN   = 16;
   localparam int TO_CYCLES = 20;
   localparam int TO_BIT    = 5;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_empty;
   logic [7:0] r_data;
   logic       rd_uart;
   logic [7:0] pl_data;
   logic       pl_valid, pl_last, frame_done, frame_err;
   logic [1:0] err_code;

   int n_checks = 0;
   int n_pass   = 0;

   uart_frame_rx #(
      .DBIT(8), .SOF(8'hA5), .MAX_LEN(MAX_LEN), .TO_CYCLES(TO_CYCLES), .TO_BIT(TO_BIT)
   ) dut (
      .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
      .rd_uart(rd_uart), .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last),
      .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       empty;
      logic [7:0] data;
      logic       v;
      logic       l;
      logic [7:0] d;
      logic       done;
      logic       err;
      logic [1:0] code;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic e, input logic [7:0] dat, input logic v,
                               input logic l, input logic [7:0] d, input logic dn,
                               input logic er, input logic [1:0] c);
      vec_t t;
      t.empty = e; t.data = dat; t.v = v; t.l = l; t.d = d;
      t.done = dn; t.err = er; t.code = c;
      return t;
   endfunction

   // Consumed byte with no visible effect.
   function automatic vec_t f_idle(input logic [7:0] dat, input logic [1:0] c);
      return mk(1'b0, dat, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, c);
   endfunction
   // Consumed payload byte.
   function automatic vec_t f_pay(input logic [7:0] dat, input logic l, input logic dn,
                                  input logic [1:0] c);
      return mk(1'b0, dat, 1'b1, l, dat, dn, 1'b0, c);
   endfunction
   // Consumed byte that aborts the frame.
   function automatic vec_t f_err(input logic [7:0] dat, input logic [1:0] c);
      return mk(1'b0, dat, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, c);
   endfunction
   // Consumed checksum byte that completes the frame.
   function automatic vec_t f_done(input logic [7:0] dat, input logic [1:0] c);
      return mk(1'b0, dat, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, c);
   endfunction
   // Empty FIFO cycle.
   function automatic vec_t f_empty(input logic er, input logic [1:0] c);
      return mk(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, er, c);
   endfunction

   // Drive one cycle of FIFO input, check the pop, then check registered outputs.
   task automatic step(input vec_t t, input string name);
      logic [5:0] got, exp;
      @(negedge clk);
      rx_empty = t.empty;
      r_data   = t.data;
      #1;
      n_checks++;
      if (rd_uart !== ~t.empty) begin
         $display("FAIL %s rd_uart: got %b expected %b", name, rd_uart, ~t.empty);
      end else begin
         n_pass++;
      end
      @(posedge clk);
      #1;
      got = {pl_valid, pl_last, frame_done, frame_err, err_code};
      exp = {t.v, t.l, t.done, t.err, t.code};
      n_checks++;
      if ((got !== exp) || (t.v && (pl_data !== t.d))) begin
         $display("FAIL %s outputs: got v/l/done/err/code=%b data=%h expected %b data=%h",
                  name, got, pl_data, exp, t.d);
      end else begin
         n_pass++;
      end
   endtask

   task automatic check_zero(input string name);
      logic [13:0] got;
      got = {pl_data, pl_valid, pl_last, frame_done, frame_err, err_code};
      n_checks++;
      if (got !== 14'd0) begin
         $display("FAIL %s: outputs got %h expected all zero", name, got);
      end else begin
         n_pass++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset    = 1'b1;
      rx_empty = 1'b1;
      r_data   = 8'h00;

      // ---------------- table ----------------
`ifdef UART_FRAME_CSUM_EN
      // 03^11^22^33 = 03
      vecs.push_back(f_idle(8'hA5, 2'd0)); vecs.push_back(f_idle(8'h03, 2'd0));
      vecs.push_back(f_pay(8'h11, 1'b0, 1'b0, 2'd0)); vecs.push_back(f_pay(8'h22, 1'b0, 1'b0, 2'd0));
      vecs.push_back(f_pay(8'h33, 1'b1, 1'b0, 2'd0)); vecs.push_back(f_done(8'h03, 2'd0));
      // same frame, wrong checksum 04
      vecs.push_back(f_idle(8'hA5, 2'd0)); vecs.push_back(f_idle(8'h03, 2'd0));
      vecs.push_back(f_pay(8'h11, 1'b0, 1'b0, 2'd0)); vecs.push_back(f_pay(8'h22, 1'b0, 1'b0, 2'd0));
      vecs.push_back(f_pay(8'h33, 1'b1, 1'b0, 2'd0)); vecs.push_back(f_err(8'h04, 2'd1));
      // back-to-back good frame, 01^55 = 54
      vecs.push_back(f_idle(8'hA5, 2'd1)); vecs.push_back(f_idle(8'h01, 2'd1));
      vecs.push_back(f_pay(8'h55, 1'b1, 1'b0, 2'd1)); vecs.push_back(f_done(8'h54, 2'd1));
      vecs.push_back(f_empty(1'b0, 2'd1));
      // junk discarded, LEN 0 and LEN 17 rejected
      vecs.push_back(f_idle(8'h00, 2'd1)); vecs.push_back(f_idle(8'h7F, 2'd1));
      vecs.push_back(f_idle(8'hA5, 2'd1)); vecs.push_back(f_err(8'h00, 2'd2));
      vecs.push_back(f_idle(8'hA5, 2'd2)); vecs.push_back(f_err(8'h11, 2'd2));
      // frame with a gap inside the payload, 02^77^88 = FD
      vecs.push_back(f_idle(8'hA5, 2'd2)); vecs.push_back(f_idle(8'h02, 2'd2));
      vecs.push_back(f_pay(8'h77, 1'b0, 1'b0, 2'd2)); vecs.push_back(f_empty(1'b0, 2'd2));
      vecs.push_back(f_pay(8'h88, 1'b1, 1'b0, 2'd2)); vecs.push_back(f_done(8'hFD, 2'd2));
      // LEN = MAX_LEN = 16, payload 01..10, checksum 10^(01^..^10) = 00
      vecs.push_back(f_idle(8'hA5, 2'd2)); vecs.push_back(f_idle(8'h10, 2'd2));
      for (int i = 1; i <= 16; i++) begin
         vecs.push_back(f_pay(8'(i), (i == 16), 1'b0, 2'd2));
      end
      vecs.push_back(f_done(8'h00, 2'd2));
`else
      vecs.push_back(f_idle(8'hA5, 2'd0)); vecs.push_back(f_idle(8'h03, 2'd0));
      vecs.push_back(f_pay(8'h11, 1'b0, 1'b0, 2'd0)); vecs.push_back(f_pay(8'h22, 1'b0, 1'b0, 2'd0));
      vecs.push_back(f_pay(8'h33, 1'b1, 1'b1, 2'd0));
      // two back-to-back single-byte frames
      vecs.push_back(f_idle(8'hA5, 2'd0)); vecs.push_back(f_idle(8'h01, 2'd0));
      vecs.push_back(f_pay(8'h55, 1'b1, 1'b1, 2'd0));
      vecs.push_back(f_idle(8'hA5, 2'd0)); vecs.push_back(f_idle(8'h01, 2'd0));
      vecs.push_back(f_pay(8'h66, 1'b1, 1'b1, 2'd0));
      vecs.push_back(f_empty(1'b0, 2'd0));
      // junk discarded, LEN 0 and LEN 17 rejected
      vecs.push_back(f_idle(8'h00, 2'd0)); vecs.push_back(f_idle(8'h7F, 2'd0));
      vecs.push_back(f_idle(8'hA5, 2'd0)); vecs.push_back(f_err(8'h00, 2'd2));
      vecs.push_back(f_idle(8'hA5, 2'd2)); vecs.push_back(f_err(8'h11, 2'd2));
      // frame with a gap inside the payload
      vecs.push_back(f_idle(8'hA5, 2'd2)); vecs.push_back(f_idle(8'h02, 2'd2));
      vecs.push_back(f_pay(8'h77, 1'b0, 1'b0, 2'd2)); vecs.push_back(f_empty(1'b0, 2'd2));
      vecs.push_back(f_pay(8'h88, 1'b1, 1'b1, 2'd2));
      // LEN = MAX_LEN = 16
      vecs.push_back(f_idle(8'hA5, 2'd2)); vecs.push_back(f_idle(8'h10, 2'd2));
      for (int i = 1; i <= 16; i++) begin
         vecs.push_back(f_pay(8'(i), (i == 16), (i == 16), 2'd2));
      end
`endif

      // ---------------- reset state ----------------
      #2;
      check_zero("reset_state");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i], $sformatf("vec%0d", i));
      end

      // ---------------- timeout fires on the TO_CYCLES-th empty cycle ----------------
      step(f_idle(8'hA5, 2'd2), "to_sof");
      step(f_idle(8'h02, 2'd2), "to_len");
      step(f_pay(8'h10, 1'b0, 1'b0, 2'd2), "to_pay");
      for (int k = 1; k <= TO_CYCLES; k++) begin
         step(f_empty((k == TO_CYCLES), (k == TO_CYCLES) ? 2'd3 : 2'd2),
              $sformatf("to_gap%0d", k));
      end
      step(f_empty(1'b0, 2'd3), "to_after");

      // ---------------- TO_CYCLES-1 empty cycles do not time out ----------------
      step(f_idle(8'hA5, 2'd3), "nto_sof");
      step(f_idle(8'h02, 2'd3), "nto_len");
      step(f_pay(8'h10, 1'b0, 1'b0, 2'd3), "nto_pay0");
      for (int k = 1; k < TO_CYCLES; k++) begin
         step(f_empty(1'b0, 2'd3), $sformatf("nto_gap%0d", k));
      end
`ifdef UART_FRAME_CSUM_EN
      step(f_pay(8'h20, 1'b1, 1'b0, 2'd3), "nto_pay1");
      // 02^10^20 = 32
      step(f_done(8'h32, 2'd3), "nto_csum");
`else
      step(f_pay(8'h20, 1'b1, 1'b1, 2'd3), "nto_pay1");
`endif

      // ---------------- reset in the middle of a frame ----------------
      step(f_idle(8'hA5, 2'd3), "rst_sof");
      step(f_idle(8'h03, 2'd3), "rst_len");
      step(f_pay(8'h11, 1'b0, 1'b0, 2'd3), "rst_pay0");
      step(f_pay(8'h22, 1'b0, 1'b0, 2'd3), "rst_pay1");
      rx_empty = 1'b1;
      reset    = 1'b1;
      #1;
      check_zero("rst_async");
      @(posedge clk);
      #1;
      check_zero("rst_hold");
      @(negedge clk);
      reset = 1'b0;
      step(f_empty(1'b0, 2'd0), "rst_quiet0");
      step(f_empty(1'b0, 2'd0), "rst_quiet1");
      step(f_idle(8'hA5, 2'd0), "post_sof");
      step(f_idle(8'h01, 2'd0), "post_len");
`ifdef UART_FRAME_CSUM_EN
      step(f_pay(8'h55, 1'b1, 1'b0, 2'd0), "post_pay");
      step(f_done(8'h54, 2'd0), "post_csum");
`else
      step(f_pay(8'h55, 1'b1, 1'b1, 2'd0), "post_pay");
`endif
      step(f_empty(1'b0, 2'd0), "post_quiet");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
